// File: rtl/itch_arb_pkg.sv
`default_nettype none
// itch_arb_pkg: shared state encoding and source ids for the ITCH feed arbiter.
// Rev 1.0
package itch_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int DEFAULT_STALL_LIMIT = 16;
  // Wide enough for the largest legal STALL_LIMIT (255).
  localparam int STALL_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/itch_stall_watchdog.sv
`default_nettype none
// itch_stall_watchdog: idle-cycle counter with one-cycle timeout pulse and sticky error flag.
// Rev 1.0
module itch_stall_watchdog
  import itch_arb_pkg::*;
#(
  parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  input  logic err_clr,
  output logic timeout,
  output logic stall_err
);

  localparam logic [STALL_CNT_W-1:0] LIMIT_M1 = STALL_CNT_W'(STALL_LIMIT - 1);

  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;

  always_comb begin
    timeout = enable && (cnt_q == LIMIT_M1);
    cnt_d   = cnt_q;
    if (kick || timeout) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
    // A new timeout outranks a simultaneous clear so no stall goes unreported.
    err_d = err_q;
    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stall_err = err_q;

endmodule
`default_nettype wire

// File: rtl/itch_feed_arbiter.sv
`default_nettype none
// itch_feed_arbiter: message-atomic two-source round-robin arbiter feeding one ITCH parser.
// Rev 1.0
module itch_feed_arbiter
  import itch_arb_pkg::*;
#(
  parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s0_byte,
  input  logic             s0_valid,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic [7:0]       s1_byte,
  input  logic             s1_valid,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic [7:0]       byte_out,
  output logic             valid_out,
  output logic             grant_id,
  output logic             busy,
  output logic             stall_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] msg_cnt0,
  output logic [CNT_W-1:0] msg_cnt1
);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_served_q, last_served_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_byte;
  logic       accept;
  logic       enter_xfer;
  logic       wd_enable;
  logic       wd_kick;
  logic       timeout;

  always_comb begin
    g_valid = (grant_q == SRC1) ? s1_valid : s0_valid;
    g_last  = (grant_q == SRC1) ? s1_last  : s0_last;
    g_byte  = (grant_q == SRC1) ? s1_byte  : s0_byte;
  end

  assign s0_ready = (state_q == XFER) && (grant_q == SRC0);
  assign s1_ready = (state_q == XFER) && (grant_q == SRC1);
  assign accept   = (state_q == XFER) && g_valid;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    byte_d        = byte_q;
    valid_d       = 1'b0;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    enter_xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          enter_xfer = 1'b1;
          state_d    = XFER;
          if (s0_valid && s1_valid) begin
            grant_d = ~last_served_q;
          end else begin
            grant_d = s1_valid ? SRC1 : SRC0;
          end
        end
      end
      XFER: begin
        if (accept) begin
          byte_d  = g_byte;
          valid_d = 1'b1;
          if (g_last) begin
            state_d       = IDLE;
            last_served_d = grant_q;
            if (grant_q == SRC0) begin
              cnt0_d = cnt0_q + CNT_W'(1);
            end else begin
              cnt1_d = cnt1_q + CNT_W'(1);
            end
          end
        end else if (timeout) begin
          // Abandon the truncated message; the other source gets the next turn.
          state_d       = IDLE;
          last_served_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wd_enable = (state_q == XFER) && !g_valid;
  assign wd_kick   = accept || enter_xfer;

  itch_stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .enable   (wd_enable),
    .kick     (wd_kick),
    .err_clr  (err_clr),
    .timeout  (timeout),
    .stall_err(stall_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= SRC0;
      last_served_q <= SRC1;
      byte_q        <= '0;
      valid_q       <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      byte_q        <= byte_d;
      valid_q       <= valid_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign byte_out  = byte_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);
  assign msg_cnt0  = cnt0_q;
  assign msg_cnt1  = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_itch_feed_arbiter.sv
`default_nettype none
// tb_itch_feed_arbiter: directed scenarios for the ITCH feed arbiter with hand-derived expectations.
// Rev 1.0
module tb_itch_feed_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    s0_byte = '0, s1_byte = '0;
  logic          s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic          s0_ready, s1_ready;
  logic [7:0]    byte_out;
  logic          valid_out, grant_id, busy, stall_err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] msg_cnt0, msg_cnt1;

  itch_feed_arbiter #(.STALL_LIMIT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s0_byte(s0_byte), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_byte(s1_byte), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .byte_out(byte_out), .valid_out(valid_out), .grant_id(grant_id), .busy(busy),
    .stall_err(stall_err), .err_clr(err_clr), .msg_cnt0(msg_cnt0), .msg_cnt1(msg_cnt1)
  );

  always #5 clk = ~clk;

  logic [8:0] q0[$], q1[$];
  logic [7:0] outq[$], expq[$];
  bit         vlog[$];
  int         hold1_left = 0;
  int         checks = 0, failures = 0, lat_err = 0;

  task automatic drive();
    s0_valid = (q0.size() > 0);
    {s0_last, s0_byte} = (q0.size() > 0) ? q0[0] : 9'h0;
    s1_valid = (q1.size() > 0) && (hold1_left == 0);
    {s1_last, s1_byte} = (q1.size() > 0) ? q1[0] : 9'h0;
  endtask

  // One clock: note handshakes seen before the edge, then check the registered output after it.
  task automatic tick();
    bit a0, a1;
    logic [7:0] ab;
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    ab = a0 ? s0_byte : s1_byte;
    @(posedge clk); #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    if (hold1_left > 0) hold1_left--;
    if ((valid_out !== (a0 || a1)) || ((a0 || a1) && (byte_out !== ab)) || (a0 && a1)) lat_err++;
    vlog.push_back(valid_out);
    if (valid_out) outq.push_back(byte_out);
    drive();
  endtask

  task automatic push_msg(input bit src, input logic [7:0] typ, input int len,
                          input logic [7:0] seed, input bit term);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e[7:0] = (i == 0) ? typ : seed + 8'(i);
      e[8]   = term && (i == len - 1);
      if (src) q1.push_back(e); else q0.push_back(e);
      expq.push_back(e[7:0]);
    end
  endtask

  function automatic int qdiff();
    int d;
    d = (outq.size() != expq.size()) ? 1 : 0;
    for (int i = 0; i < outq.size() && i < expq.size(); i++)
      if (outq[i] !== expq[i]) d++;
    return d;
  endfunction

  function automatic int inner_gaps();
    int f, l, z;
    f = -1; l = -1; z = 0;
    for (int i = 0; i < vlog.size(); i++)
      if (vlog[i]) begin
        if (f < 0) f = i;
        l = i;
      end
    if (f >= 0)
      for (int i = f; i <= l; i++) if (!vlog[i]) z++;
    return z;
  endfunction

  task automatic clear_logs();
    outq.delete(); expq.delete(); vlog.delete(); lat_err = 0;
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); hold1_left = 0; err_clr = 1'b0; drive();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin tick(); n++; end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      failures++; $display("FAIL %s_drain: %0d/%0d bytes left after %0d cycles, want 0", tag, q0.size(), q1.size(), max_cyc);
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid_out, busy, grant_id, stall_err, s0_ready, s1_ready} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 000000", {valid_out, busy, grant_id, stall_err, s0_ready, s1_ready});
    end
    checks++;
    if ({byte_out, msg_cnt0, msg_cnt1} !== '0) begin
      failures++; $display("FAIL reset_data: byte=%h cnt0=%0d cnt1=%0d want 0", byte_out, msg_cnt0, msg_cnt1);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    push_msg(0, 8'h41, 36, 8'h10, 1); drive();
    drain(100, "single");
    checks++; if (qdiff() != 0) begin failures++; $display("FAIL single_data: %0d diffs, %0d bytes out, want 0 diffs, 36 bytes", qdiff(), outq.size()); end
    checks++; if (lat_err != 0) begin failures++; $display("FAIL single_latency: %0d bad cycles, want 0", lat_err); end
    checks++; if (vlog[0] !== 1'b0 || vlog[1] !== 1'b1) begin failures++; $display("FAIL single_first: valid %b%b want 01", vlog[0], vlog[1]); end
    checks++; if (msg_cnt0 !== 4'd1 || msg_cnt1 !== 4'd0) begin failures++; $display("FAIL single_cnt: got %0d/%0d want 1/0", msg_cnt0, msg_cnt1); end
    checks++; if (grant_id !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_grant: grant=%b busy=%b want 0 0", grant_id, busy); end
  endtask

  task automatic test_contention();
    do_reset();
    push_msg(0, 8'h44, 19, 8'h20, 1);
    push_msg(1, 8'h44, 19, 8'h60, 1); drive();
    drain(200, "cont1");
    checks++; if (qdiff() != 0) begin failures++; $display("FAIL cont1_order: %0d diffs, %0d bytes, want s0 then s1", qdiff(), outq.size()); end
    checks++; if (inner_gaps() != 1) begin failures++; $display("FAIL cont1_gap: got %0d idle cycles want 1", inner_gaps()); end
    checks++; if (msg_cnt0 !== 4'd1 || msg_cnt1 !== 4'd1) begin failures++; $display("FAIL cont1_cnt: got %0d/%0d want 1/1", msg_cnt0, msg_cnt1); end
    clear_logs();
    push_msg(0, 8'h44, 19, 8'h30, 1);
    push_msg(1, 8'h44, 19, 8'h70, 1); drive();
    drain(200, "cont2");
    checks++; if (qdiff() != 0) begin failures++; $display("FAIL cont2_order: %0d diffs, %0d bytes, want s0 then s1", qdiff(), outq.size()); end
    checks++; if (inner_gaps() != 1) begin failures++; $display("FAIL cont2_gap: got %0d idle cycles want 1", inner_gaps()); end
    checks++; if (msg_cnt0 !== 4'd2 || msg_cnt1 !== 4'd2) begin failures++; $display("FAIL cont2_cnt: got %0d/%0d want 2/2", msg_cnt0, msg_cnt1); end
    checks++; if (lat_err != 0) begin failures++; $display("FAIL cont_latency: %0d bad cycles want 0", lat_err); end
  endtask

  task automatic test_gap();
    int n;
    bit armed;
    n = 0; armed = 0;
    do_reset();
    push_msg(1, 8'h45, 23, 8'h80, 1); drive();
    while (q1.size() > 0 && n < 200) begin
      tick(); n++;
      if (!armed && q1.size() == 13) begin armed = 1; hold1_left = 5; drive(); end
    end
    tick(); tick();
    checks++; if (qdiff() != 0) begin failures++; $display("FAIL gap_data: %0d diffs, %0d bytes, want 0 diffs, 23 bytes", qdiff(), outq.size()); end
    checks++; if (inner_gaps() != 5) begin failures++; $display("FAIL gap_idle: got %0d idle cycles want 5", inner_gaps()); end
    checks++; if (stall_err !== 1'b0 || grant_id !== 1'b1) begin failures++; $display("FAIL gap_state: stall=%b grant=%b want 0 1", stall_err, grant_id); end
    checks++; if (msg_cnt1 !== 4'd1) begin failures++; $display("FAIL gap_cnt1: got %0d want 1", msg_cnt1); end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    do_reset();
    push_msg(0, 8'h41, 4, 8'h90, 0);
    push_msg(1, 8'h44, 5, 8'hA0, 1); drive();
    while (q0.size() > 0 && n < 50) begin tick(); n++; end
    repeat (15) tick();
    checks++; if (stall_err !== 1'b0 || busy !== 1'b1 || grant_id !== 1'b0) begin failures++; $display("FAIL stall_early: stall=%b busy=%b grant=%b want 0 1 0", stall_err, busy, grant_id); end
    tick();
    checks++; if (stall_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL stall_fire: stall=%b busy=%b want 1 0", stall_err, busy); end
    tick();
    checks++; if (busy !== 1'b1 || grant_id !== 1'b1) begin failures++; $display("FAIL stall_regrant: busy=%b grant=%b want 1 1", busy, grant_id); end
    drain(50, "stall");
    checks++; if (qdiff() != 0) begin failures++; $display("FAIL stall_data: %0d diffs want 0", qdiff()); end
    checks++; if (msg_cnt0 !== 4'd0 || msg_cnt1 !== 4'd1 || stall_err !== 1'b1) begin failures++; $display("FAIL stall_cnt: cnt=%0d/%0d stall=%b want 0/1 1", msg_cnt0, msg_cnt1, stall_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL stall_clr: got %b want 0", stall_err); end
    push_msg(0, 8'h41, 2, 8'hB0, 0); drive();
    n = 0;
    while (q0.size() > 0 && n < 50) begin tick(); n++; end
    repeat (15) tick();
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL stall_pre2: got %b want 0", stall_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL stall_setwins: got %b want 1", stall_err); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    do_reset();
    push_msg(0, 8'h41, 1, 8'h00, 1); drive();
    drain(20, "rmid_pre");
    checks++; if (msg_cnt0 !== 4'd1) begin failures++; $display("FAIL rmid_pre_cnt0: got %0d want 1", msg_cnt0); end
    push_msg(1, 8'h41, 30, 8'hC0, 1); drive();
    while (q1.size() > 23 && n < 50) begin tick(); n++; end
    rst = 1'b0; #1;
    checks++; if ({valid_out, busy, grant_id, s0_ready, s1_ready} !== 5'b0 || byte_out !== 8'h00) begin
      failures++; $display("FAIL rmid_async: v/b/g/r0/r1=%b byte=%h want 00000 00", {valid_out, busy, grant_id, s0_ready, s1_ready}, byte_out);
    end
    checks++; if (msg_cnt0 !== 4'd0 || msg_cnt1 !== 4'd0) begin failures++; $display("FAIL rmid_cnt: got %0d/%0d want 0/0", msg_cnt0, msg_cnt1); end
    q1.delete(); drive();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_logs();
    push_msg(1, 8'h44, 19, 8'hD0, 1); drive();
    drain(100, "rmid_post");
    checks++; if (qdiff() != 0 || lat_err != 0) begin failures++; $display("FAIL rmid_data: %0d diffs %0d latency errs want 0 0", qdiff(), lat_err); end
    checks++; if (grant_id !== 1'b1 || msg_cnt0 !== 4'd0 || msg_cnt1 !== 4'd1) begin
      failures++; $display("FAIL rmid_after: grant=%b cnt=%0d/%0d want 1 0/1", grant_id, msg_cnt0, msg_cnt1);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    do_reset();
    for (int i = 0; i < 17; i++) push_msg(0, 8'(i + 1), 1, 8'h00, 1);
    drive();
    while (q0.size() > 1 && n < 100) begin tick(); n++; end
    checks++; if (msg_cnt0 !== 4'd0) begin failures++; $display("FAIL wrap_16: got %0d want 0", msg_cnt0); end
    drain(20, "wrap");
    checks++; if (msg_cnt0 !== 4'd1) begin failures++; $display("FAIL wrap_17: got %0d want 1", msg_cnt0); end
    checks++; if (qdiff() != 0 || inner_gaps() != 16) begin failures++; $display("FAIL wrap_stream: %0d diffs %0d gaps want 0 16", qdiff(), inner_gaps()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_gap();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
